core_run_ctrl: RTL
==================

# core_run_ctrl

Run/step/halt controller for the single-cycle RV32I core. It sequences the core through its `clk_enable` input and accepts host commands: free run, execute N instructions, halt. It parks the core only at instruction boundaries, stops on an optional PC breakpoint, and counts retired instructions. It sits between the debug host interface and the core's `clk_enable`, `cycle_end` and `dbg_*` ports.

## Interface
Parameters:
- STEP_W, 16, width of the step-count argument
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accepted when valid&ready at posedge
- cmd_op  in  2  0 HALT, 1 RUN, 2 STEP, 3 CLR_CNT
- cmd_arg  in  STEP_W  instruction count for STEP
- core_clk_enable  out  1  core advances on a posedge only when high
- core_cycle_end  in  1  core last tick of instruction
- core_state  in  4  core dbg_state
- core_pc  in  32  core dbg_pc
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC
- halted  out  1  controller is PARKED or FAULT
- ctrl_state  out  2  0 PARKED, 1 RUN, 2 STEP, 3 FAULT
- stop_cause  out  2  0 HALT_CMD, 1 STEP_DONE, 2 BREAKPOINT, 3 CORE_STOP
- retired  out  CNT_W  retired-instruction count

## Operation
- Core state codes: INIT=0, FETCH=1, WRITEBACK=5, HALT=6, ERROR=7.
- Every park happens with core_state==FETCH, so the core is frozen before the instruction at core_pc executes.
- core_clk_enable is combinational: (ctrl_state is RUN or STEP) && !(core_state==FETCH && park_req).
- park_req = halt_pend | bp_hit | (STEP && steps_left==0).
- bp_hit = bp_en & core_state==FETCH & core_pc==bp_addr & !bp_skip.
- Retire: a posedge with core_clk_enable & core_cycle_end & core_state==WRITEBACK increments retired (wraps modulo 2^CNT_W) and decrements steps_left in STEP.
- PARKED:
  - RUN goes to RUN.
  - STEP loads steps_left = cmd_arg (0 treated as 1) and goes to STEP.
  - Both set bp_skip.
  - HALT is a no-op.
- RUN/STEP:
  - HALT sets halt_pend.
  - RUN and STEP are accepted and dropped.
  - A park goes to PARKED and clears halt_pend.
- bp_skip clears at the first enabled posedge with core_state==FETCH. This lets a resume step off a breakpoint.
- stop_cause priority on simultaneous causes: BREAKPOINT > STEP_DONE > HALT_CMD.
- core_state HALT or ERROR while in RUN/STEP goes to FAULT with stop_cause=CORE_STOP. In FAULT, RUN/STEP/HALT are dropped.
- FAULT goes to PARKED when core_state==INIT (core was reset).
- CLR_CNT zeroes retired in any state. If a retire lands on the same edge, the clear wins.
- cmd_ready = !halt_pend.

## Timing
- Reset values:
  - cmd_ready=1, core_clk_enable=0, halted=1
  - ctrl_state=PARKED, stop_cause=0, retired=0
  - halt_pend=0, bp_skip=0, steps_left=0
- rst_n mid-run: everything returns to reset values immediately, asynchronously.
- RUN/STEP accepted at edge t: ctrl_state changes at t, so core_clk_enable is high in the cycle after t.
- HALT latency:
  - core_clk_enable drops in the first cycle after acceptance with core_state==FETCH (≤5 cycles).
  - halted rises on the following edge.
  - cmd_ready stays low throughout.
- Step completion: after the Nth retiring edge the core is in FETCH. Enable is low in that same cycle, so zero extra ticks execute.
- STEP N from an instruction boundary takes exactly 5·N enabled cycles.
- Only registered state is exposed on ctrl_state, halted, stop_cause and retired. core_clk_enable is the only combinational output.

## Configuration
- RUN_CTRL_BP_EN defined: breakpoint logic (bp_hit, bp_skip) is built.
- Undefined:
  - bp_hit is constant 0.
  - bp_en and bp_addr are ignored.
  - stop_cause never reports BREAKPOINT.
  - The port list is unchanged.

## Structure
- The shared package core_dbg_pkg holds:
  - core state codes (must match the core's state defines)
  - ctrl_state encoding
  - cmd_op encoding
  - stop_cause encoding
- One sub-module: run_ctrl_bp_match (comparator plus bp_skip flag), instantiated only under RUN_CTRL_BP_EN.

## Test plan
- Reset, then RUN; program is 3× ADDI then ECALL. Required: retired=3, ctrl_state=FAULT, stop_cause=3, halted=1.
- From PARKED at PC 0, STEP cmd_arg=2. Required:
  - park with core_pc=0x8, core_state=FETCH
  - retired=2, stop_cause=1
  - enable high exactly 10 cycles
- bp_en=1, bp_addr=0x10, RUN. Required:
  - park with core_pc=0x10, stop_cause=2
  - a second RUN executes 0x10 and continues without re-hitting
- HALT issued while core is in EXECUTE. Required:
  - cmd_ready low until park
  - enable low in the next FETCH cycle
  - stop_cause=0
  - a RUN issued while halt_pend is not accepted
- STEP cmd_arg=0 retires exactly 1 instruction. STEP 1 ending at bp_addr reports stop_cause=2.
- rst_n pulsed low mid-RUN: all outputs take reset values within the same cycle, and retired=0.

Source files
------------

// File: rtl/core_dbg_pkg.sv
// core_dbg_pkg: shared encodings for the core debug/run-control slice.
// Core state codes must track the core's own state defines.
package core_dbg_pkg;

  localparam logic [3:0] CORE_INIT  = 4'd0;
  localparam logic [3:0] CORE_FETCH = 4'd1;
  localparam logic [3:0] CORE_WB    = 4'd5;
  localparam logic [3:0] CORE_HALT  = 4'd6;
  localparam logic [3:0] CORE_ERROR = 4'd7;

  typedef enum logic [1:0] {
    CTRL_PARKED = 2'd0,
    CTRL_RUN    = 2'd1,
    CTRL_STEP   = 2'd2,
    CTRL_FAULT  = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    OP_HALT    = 2'd0,
    OP_RUN     = 2'd1,
    OP_STEP    = 2'd2,
    OP_CLR_CNT = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    STOP_HALT_CMD   = 2'd0,
    STOP_STEP_DONE  = 2'd1,
    STOP_BREAKPOINT = 2'd2,
    STOP_CORE_STOP  = 2'd3
  } stop_cause_e;

  function automatic logic core_is_stopped(
    input logic [3:0] st
  );
    return (st == CORE_HALT) || (st == CORE_ERROR);
  endfunction

  // Breakpoint outranks step completion, which outranks a host halt.
  function automatic stop_cause_e park_cause(
    input logic bp,
    input logic step_done
  );
    if (bp)
      return STOP_BREAKPOINT;
    else if (step_done)
      return STOP_STEP_DONE;
    else
      return STOP_HALT_CMD;
  endfunction

endpackage

// File: rtl/run_ctrl_bp_match.sv
// run_ctrl_bp_match: PC breakpoint comparator with a one-shot skip flag.
// The skip flag lets a resume step off the instruction it parked on.
module run_ctrl_bp_match
  import core_dbg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] core_pc,
  input  logic [3:0]  core_state,
  input  logic        skip_set,
  input  logic        tick_en,
  output logic        bp_hit
);

  logic skip_q;
  logic skip_d;
  logic at_fetch;

  assign at_fetch = (core_state == CORE_FETCH);
  assign bp_hit   = bp_en & at_fetch
                  & (core_pc == bp_addr) & ~skip_q;

  // Arm on resume, disarm once the core leaves its first fetch.
  always_comb begin
    skip_d = skip_q;
    if (skip_set)
      skip_d = 1'b1;
    else if (tick_en && at_fetch)
      skip_d = 1'b0;
  end

  // Skip flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      skip_q <= 1'b0;
    else
      skip_q <= skip_d;
  end

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/step/halt sequencer driving the core clock enable.
// Breakpoint logic is built only when RUN_CTRL_BP_EN is defined.
module core_run_ctrl
  import core_dbg_pkg::*;
#(
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              core_clk_enable,
  input  logic              core_cycle_end,
  input  logic [3:0]        core_state,
  input  logic [31:0]       core_pc,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  output logic              halted,
  output logic [1:0]        ctrl_state,
  output logic [1:0]        stop_cause,
  output logic [CNT_W-1:0]  retired
);

  ctrl_state_e       state_q, state_d;
  stop_cause_e       cause_q, cause_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              halt_pend_q, halt_pend_d;
  logic              halted_q, halted_d;

  cmd_op_e op;
  logic    cmd_fire;
  logic    active;
  logic    at_fetch;
  logic    bp_hit;
  logic    step_done;
  logic    park_req;
  logic    park;
  logic    retire;
  logic    resume;
  logic    stopped;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = ~halt_pend_q;
  assign cmd_fire  = cmd_valid & cmd_ready;

  assign active    = (state_q == CTRL_RUN)
                   | (state_q == CTRL_STEP);
  assign at_fetch  = (core_state == CORE_FETCH);
  assign step_done = (state_q == CTRL_STEP)
                   & (steps_q == '0);
  assign park_req  = halt_pend_q | bp_hit | step_done;
  assign park      = active & at_fetch & park_req;
  assign stopped   = core_is_stopped(core_state);

  assign core_clk_enable = active & ~(at_fetch & park_req);

  assign retire = core_clk_enable & core_cycle_end
                & (core_state == CORE_WB);

  assign resume = cmd_fire & (state_q == CTRL_PARKED)
                & ((op == OP_RUN) | (op == OP_STEP));

`ifdef RUN_CTRL_BP_EN
  run_ctrl_bp_match u_bp (
    .clk        (clk),
    .rst_n      (rst_n),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .core_pc    (core_pc),
    .core_state (core_state),
    .skip_set   (resume),
    .tick_en    (core_clk_enable),
    .bp_hit     (bp_hit)
  );
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, core_pc};
  assign bp_hit    = 1'b0;
`endif

  assign halted     = halted_q;
  assign ctrl_state = state_q;
  assign stop_cause = cause_q;
  assign retired    = retired_q;

  // Next-state: command handling, parking, fault entry and counting.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    halt_pend_d = halt_pend_q;
    steps_d     = steps_q;
    retired_d   = retired_q;

    if (cmd_fire && op == OP_CLR_CNT)
      retired_d = '0;
    else if (retire)
      retired_d = retired_q + CNT_W'(1);

    if (retire && state_q == CTRL_STEP)
      steps_d = steps_q - STEP_W'(1);

    unique case (state_q)
      CTRL_PARKED: begin
        if (resume) begin
          if (op == OP_RUN) begin
            state_d = CTRL_RUN;
          end else begin
            state_d = CTRL_STEP;
            steps_d = (cmd_arg == '0)
                    ? STEP_W'(1) : cmd_arg;
          end
        end
      end
      CTRL_RUN, CTRL_STEP: begin
        if (stopped) begin
          state_d     = CTRL_FAULT;
          cause_d     = STOP_CORE_STOP;
          halt_pend_d = 1'b0;
        end else if (park) begin
          state_d     = CTRL_PARKED;
          cause_d     = park_cause(bp_hit, step_done);
          halt_pend_d = 1'b0;
        end else if (cmd_fire && op == OP_HALT) begin
          halt_pend_d = 1'b1;
        end
      end
      CTRL_FAULT: begin
        if (core_state == CORE_INIT)
          state_d = CTRL_PARKED;
      end
    endcase

    halted_d = (state_d == CTRL_PARKED)
             | (state_d == CTRL_FAULT);
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CTRL_PARKED;
      cause_q     <= STOP_HALT_CMD;
      retired_q   <= '0;
      steps_q     <= '0;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      retired_q   <= retired_d;
      steps_q     <= steps_d;
      halt_pend_q <= halt_pend_d;
      halted_q    <= halted_d;
    end
  end

endmodule
